// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-access stage: load/store size encodings
// and the access state machine encoding.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables and lane replication, load
// byte/halfword extraction with sign/zero extension, and the alignment check.
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent enables, store replication, load extension and fault flag.
  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    load_data  = 32'd0;
    misaligned = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'd0, byte_sel};
      end
      F3_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        load_data  = {16'd0, half_sel};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = |addr_lo;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Non-memory instructions and faulting memory
// operations pass straight through in IDLE; legal accesses are latched, issued
// to data memory in BUSY (stalling upstream) and reported for one cycle in DONE.
//
// Handshake: dmem_req stays high from the first BUSY cycle until the cycle in
// which dmem_ready is sampled high; that cycle completes the access and rdata
// is taken in that same cycle. dmem_ready outside BUSY is ignored.
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic [4:0]  rd_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic [1:0]  dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  ms_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic        is_load_q;
  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        bus_err_q;

  logic        busy;
  logic        is_mem;
  logic        accept;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_mis;

  assign busy   = (state_q == MS_BUSY);
  assign is_mem = mem_read_in | mem_write_in;
  // In IDLE the aligner checks the incoming op; in BUSY it formats the read
  // word using the latched size and lane.
  assign al_f3  = busy ? f3_q : funct3_in;
  assign al_lo  = busy ? addr_q[1:0] : alu_result_in[1:0];
  assign accept = (state_q == MS_IDLE) && in_valid && is_mem && !al_mis;

  load_store_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .store_data (store_data_in),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  // Access FSM: latch on accept, wait for ready or timeout, report once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MS_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      is_load_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (accept) begin
            addr_q       <= alu_result_in;
            f3_q         <= funct3_in;
            rd_q         <= rd_in;
            we_q         <= mem_write_in;
            is_load_q    <= mem_read_in & ~mem_write_in;
            reg_write_q  <= reg_write_in;
            mem_to_reg_q <= mem_to_reg_in;
            be_q         <= mem_write_in ? al_be : 4'b0000;
            wdata_q      <= al_wdata;
            data_q       <= '0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
            state_q      <= MS_BUSY;
          end
        end
        MS_BUSY: begin
          if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
          if (dmem_ready) begin
            data_q  <= is_load_q ? al_load : 32'd0;
            state_q <= MS_DONE;
          end else if (cnt_q >= TO_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= MS_DONE;
          end
        end
        MS_DONE: state_q <= MS_IDLE;
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  // Result bundle and handshake outputs selected by state; reset forces the
  // control/status outputs low.
  always_comb begin
    dmem_req       = 1'b0;
    stall          = 1'b0;
    out_valid      = 1'b0;
    reg_write_out  = 1'b0;
    mem_to_reg_out = 1'b0;
    rd_out         = rd_in;
    read_data_out  = 32'd0;
    alu_result_out = alu_result_in;
    misaligned_out = 1'b0;
    bus_err_out    = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid      = 1'b1;
            reg_write_out  = reg_write_in;
            mem_to_reg_out = mem_to_reg_in;
          end else if (al_mis) begin
            out_valid      = 1'b1;
            misaligned_out = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end
      MS_BUSY: begin
        dmem_req       = 1'b1;
        stall          = 1'b1;
        rd_out         = rd_q;
        alu_result_out = addr_q;
      end
      MS_DONE: begin
        out_valid      = 1'b1;
        rd_out         = rd_q;
        alu_result_out = addr_q;
        read_data_out  = data_q;
        reg_write_out  = reg_write_q & ~bus_err_q;
        mem_to_reg_out = mem_to_reg_q & ~bus_err_q;
        bus_err_out    = bus_err_q;
      end
      default: ;
    endcase
    if (reset) begin
      dmem_req       = 1'b0;
      stall          = 1'b0;
      out_valid      = 1'b0;
      misaligned_out = 1'b0;
      bus_err_out    = 1'b0;
    end
  end

  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases followed by randomized ops, all
// checked against a size/lane arithmetic model of the stage.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, out_valid, reg_write_out, mem_to_reg_out;
  logic [4:0]  rd_out;
  logic [31:0] read_data_out, alu_result_out;
  logic        misaligned_out, bus_err_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
    .out_valid(out_valid), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .rd_out(rd_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (addr % 2) != 0;
      3'b010:         return (addr % 4) != 0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (addr % 4))) & 32'hFF;
    h = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'b000, 3'b100: return 32'd1 << (addr % 4);
      3'b001, 3'b101: return 32'd3 << (2 * ((addr % 4) / 2));
      default:        return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000, 3'b100: return (d & 32'hFF) * 32'h01010101;
      3'b001, 3'b101: return (d & 32'hFFFF) * 32'h00010001;
      default:        return d;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic scramble_inputs();
    in_valid      = 1'($urandom);
    mem_read_in   = 1'($urandom);
    mem_write_in  = 1'($urandom);
    mem_to_reg_in = 1'($urandom);
    reg_write_in  = 1'($urandom);
    funct3_in     = 3'($urandom);
    rd_in         = 5'($urandom);
    alu_result_in = $urandom;
    store_data_in = $urandom;
  endtask

  task automatic run_bubble();
    @(negedge clk);
    scramble_inputs();
    in_valid   = 1'b0;
    dmem_ready = 1'($urandom);
    dmem_rdata = $urandom;
    #1;
    check_eq("bubble_valid", out_valid, 0);
    check_eq("bubble_stall", stall, 0);
    check_eq("bubble_req", dmem_req, 0);
  endtask

  task automatic run_alu_op(input logic [4:0] rd, input logic [31:0] res,
                            input logic rw, input logic mtr);
    @(negedge clk);
    in_valid = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
    reg_write_in = rw; mem_to_reg_in = mtr;
    funct3_in = 3'($urandom); rd_in = rd; alu_result_in = res;
    store_data_in = $urandom; dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    #1;
    check_eq("alu_valid", out_valid, 1);
    check_eq("alu_stall", stall, 0);
    check_eq("alu_req", dmem_req, 0);
    check_eq("alu_result", alu_result_out, res);
    check_eq("alu_rd", rd_out, rd);
    check_eq("alu_rw", reg_write_out, rw);
    check_eq("alu_mtr", mem_to_reg_out, mtr);
    check_eq("alu_rdata", read_data_out, 0);
    check_eq("alu_mis", misaligned_out, 0);
  endtask

  // ready_at: BUSY cycle (1-based) in which dmem_ready is driven; 0 or >TO means never.
  task automatic run_mem_op(input logic rd_en, input logic wr_en, input logic mtr,
                            input logic rw, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input int ready_at, input logic [31:0] rdata);
    bit is_store, is_load, timed_out;
    int stall_seen, exp_stall;
    logic [31:0] exp_rd;
    is_store = wr_en;
    is_load  = rd_en && !wr_en;
    @(negedge clk);
    in_valid = 1'b1; mem_read_in = rd_en; mem_write_in = wr_en;
    mem_to_reg_in = mtr; reg_write_in = rw; funct3_in = f3; rd_in = rd;
    alu_result_in = addr; store_data_in = sd;
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    #1;
    if (model_fault(f3, addr)) begin
      check_eq("flt_valid", out_valid, 1);
      check_eq("flt_mis", misaligned_out, 1);
      check_eq("flt_rw", reg_write_out, 0);
      check_eq("flt_mtr", mem_to_reg_out, 0);
      check_eq("flt_stall", stall, 0);
      check_eq("flt_req", dmem_req, 0);
      check_eq("flt_rd", rd_out, rd);
      return;
    end
    check_eq("det_stall", stall, 1);
    check_eq("det_valid", out_valid, 0);
    check_eq("det_req", dmem_req, 0);
    stall_seen = int'(stall);
    exp_q.push_back(is_load ? model_load(f3, addr, rdata) : 32'd0);
    timed_out = 0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      scramble_inputs();
      dmem_ready = (k == ready_at);
      dmem_rdata = (k == ready_at) ? rdata : $urandom;
      #1;
      stall_seen += int'(stall);
      check_eq("busy_req", dmem_req, 1);
      check_eq("busy_we", dmem_we, is_store);
      check_eq("busy_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check_eq("busy_be", dmem_be, is_store ? model_be(f3, addr) : 32'd0);
      if (is_store) check_eq("busy_wdata", dmem_wdata, model_wdata(f3, sd));
      if (k == ready_at) break;
      if (k == TO) timed_out = 1;
    end
    @(negedge clk);
    scramble_inputs();
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    #1;
    exp_rd = exp_q.pop_front();
    if (timed_out) exp_rd = 32'd0;
    exp_stall = 1 + ((ready_at >= 1 && ready_at <= TO) ? ready_at : TO);
    check_eq("stall_cycles", stall_seen, exp_stall);
    check_eq("done_valid", out_valid, 1);
    check_eq("done_stall", stall, 0);
    check_eq("done_req", dmem_req, 0);
    check_eq("done_rdata", read_data_out, exp_rd);
    check_eq("done_rd", rd_out, rd);
    check_eq("done_alu", alu_result_out, addr);
    check_eq("done_rw", reg_write_out, timed_out ? 1'b0 : rw);
    check_eq("done_mtr", mem_to_reg_out, timed_out ? 1'b0 : mtr);
    check_eq("done_buserr", bus_err_out, timed_out);
    check_eq("done_mis", misaligned_out, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    in_valid = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
    funct3_in = 0; rd_in = 0; alu_result_in = 0; store_data_in = 0;
    dmem_ready = 0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_mis", misaligned_out, 0);
    check_eq("rst_buserr", bus_err_out, 0);
    @(negedge clk);
    reset = 1'b0;
    run_bubble();

    // Directed cases
    run_mem_op(1, 0, 1, 1, 3'b010, 5'd7, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    run_mem_op(1, 0, 1, 1, 3'b000, 5'd8, 32'h103, 32'h0, 1, 32'h80FF1234);
    run_mem_op(1, 0, 1, 1, 3'b100, 5'd9, 32'h103, 32'h0, 1, 32'h80FF1234);
    run_mem_op(0, 1, 0, 0, 3'b001, 5'd0, 32'h102, 32'h0000ABCD, 1, 32'h0);
    run_mem_op(1, 0, 1, 1, 3'b010, 5'd3, 32'h101, 32'h0, 1, 32'h0);
    run_alu_op(5'd5, 32'h2A, 1'b1, 1'b0);
    run_mem_op(1, 0, 1, 1, 3'b010, 5'd4, 32'h200, 32'h0, 0, 32'h12345678);
    run_mem_op(1, 1, 0, 0, 3'b010, 5'd6, 32'h300, 32'hCAFEF00D, 3, 32'h0);

    // Reset during BUSY: request drops next cycle, late response discarded
    @(negedge clk);
    in_valid = 1; mem_read_in = 1; mem_write_in = 0; mem_to_reg_in = 1; reg_write_in = 1;
    funct3_in = 3'b010; rd_in = 5'd11; alu_result_in = 32'h400; dmem_ready = 0;
    #1;
    check_eq("rb_det_stall", stall, 1);
    @(negedge clk);
    scramble_inputs(); dmem_ready = 0;
    #1;
    check_eq("rb_busy_req", dmem_req, 1);
    @(negedge clk);
    reset = 1'b1; in_valid = 0; dmem_ready = 0;
    #1;
    check_eq("rb_in_rst_req", dmem_req, 0);
    check_eq("rb_in_rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0; in_valid = 0; dmem_ready = 1; dmem_rdata = $urandom;
    #1;
    check_eq("rb_after_req", dmem_req, 0);
    check_eq("rb_after_stall", stall, 0);
    check_eq("rb_after_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 0; dmem_ready = 0;
    #1;
    check_eq("rb_late_valid", out_valid, 0);
    check_eq("rb_late_buserr", bus_err_out, 0);

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        run_alu_op(5'($urandom), $urandom, 1'($urandom), 1'($urandom));
      end else if (kind == 2) begin
        run_bubble();
      end else begin
        logic rd_en, wr_en;
        logic [2:0] f3;
        logic [31:0] addr;
        int pick;
        wr_en = 1'($urandom_range(0, 2) == 0);
        rd_en = wr_en ? 1'($urandom) : 1'b1;
        pick  = int'($urandom_range(0, 11));
        if (pick == 0) f3 = 3'($urandom_range(6, 7));
        else if (pick == 1) f3 = 3'b011;
        else if (wr_en) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'b011) f3 = 3'b101;
        end
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (f3 == 3'b010) addr[1:0] = 2'b00;
          else if (f3 == 3'b001 || f3 == 3'b101) addr[0] = 1'b0;
        end
        run_mem_op(rd_en, wr_en, !wr_en, !wr_en, f3, 5'($urandom), addr, $urandom,
                   int'($urandom_range(1, TO + 1)), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs loads and stores to data memory over a request/ready handshake, aligns and sign-extends load data, and generates byte enables for stores. It stalls the upstream pipeline while an access is outstanding and presents a one-cycle-valid result bundle that the MEM/WB register captures.

## Interface
- TIMEOUT_CYCLES, 255: number of BUSY cycles without `dmem_ready` before the access is aborted with a bus error.
- clk  in  1  Pipeline clock. All state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- mem_read_in / mem_write_in / mem_to_reg_in / reg_write_in  in  1 each  Control bits from EX/MEM.
- funct3_in  in  3  Access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_in  in  5  Destination register.
- alu_result_in  in  32  Effective address, or ALU result for non-memory instructions.
- store_data_in  in  32  rs2 value for stores.
- dmem_req  out  1  Access request. Held high until `dmem_ready` is sampled.
- dmem_we  out  1  Write strobe (store).
- dmem_addr  out  32  Word-aligned address `{addr[31:2],2'b00}`.
- dmem_wdata  out  32  Lane-replicated store data.
- dmem_be  out  4  Byte enables.
- dmem_ready  in  1  Memory accepts or completes the access in this cycle.
- dmem_rdata  in  32  Read word. Valid when `dmem_ready` is high.
- stall  out  1  Freeze PC, IF/ID, ID/EX and EX/MEM.
- out_valid  out  1  Result bundle valid for MEM/WB capture.
- reg_write_out / mem_to_reg_out  out  1 each  Forwarded controls. Forced to 0 on any fault.
- rd_out  out  5
- read_data_out  out  32  Formatted load data.
- alu_result_out  out  32
- misaligned_out  out  1  Misaligned address or unsupported funct3 on a memory operation.
- bus_err_out  out  1  Access timed out.

## Operation
- States are IDLE, BUSY and DONE. On reset the state is IDLE and all internal registers are 0.
- While `reset` is high, `dmem_req`, `stall`, `out_valid`, `misaligned_out` and `bus_err_out` are all 0.
- IDLE with a non-memory instruction (`in_valid`, neither read nor write): the inputs pass through combinationally, with `out_valid=1`, `stall=0` and `read_data_out=0`.
- IDLE with a faulting memory operation: this covers a halfword access with `addr[0]=1`, a word access with `addr[1:0]≠0`, or an unsupported funct3.
  - Outputs: `out_valid=1`, `misaligned_out=1`, `reg_write_out=0`, `mem_to_reg_out=0`.
  - No request is issued and `stall=0`.
- IDLE with a legal memory operation:
  - Outputs: `stall=1`, `out_valid=0`.
  - The address, funct3, controls, rd and store data are latched.
  - The state moves to BUSY.
  - If both read and write are set, the access is treated as a store.
- BUSY: `dmem_req=1` and `stall=1`; the `dmem_*` outputs come from the latched values and ignore changes on the inputs.
  - On `dmem_ready`, the formatted `dmem_rdata` is captured and the state moves to DONE.
  - A timeout counter increments in every BUSY cycle. When it reaches TIMEOUT_CYCLES, the state moves to DONE with the bus-error flag set.
- DONE: `stall=0`, `out_valid=1`, outputs come from the latched registers, and `dmem_req=0`. The next state is IDLE.
  - On a bus error, `bus_err_out=1` and `reg_write_out=0`.
- Load formatting uses lane `addr[1:0]`:
  - LB / LBU: the selected byte, sign-extended or zero-extended.
  - LH / LHU: the halfword at `addr[1]`, sign-extended or zero-extended.
  - LW: the whole word.
- Store formatting:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{data[7:0]}}`.
  - SH: `be = 4'b0011 << {addr[1],1'b0}`, `wdata = {2{data[15:0]}}`.
  - SW: `be = 4'b1111`.
  - For loads, `be` is 0.
  - For stores, `reg_write_out` follows the input control, which the decoder sets to 0.

## Timing
- Memory operations have a minimum latency of 3 cycles: the IDLE detect cycle, one BUSY cycle with `dmem_ready`, then the DONE cycle.
- `stall` is high for the IDLE detect cycle plus every BUSY cycle. It falls in the DONE cycle.
- `dmem_ready` sampled outside BUSY is ignored.
- Synchronous reset during BUSY: `dmem_req` is 0 from the next cycle, and any late response is discarded.
- The timeout counter clears on entry to BUSY and saturates.

## Structure
- Package `riscv_mem_pkg` holds:
  - the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state enum (`MS_IDLE`, `MS_BUSY`, `MS_DONE`).
- One combinational sub-module, `load_store_align`, takes funct3, `addr[1:0]`, store data and read word. It produces `be`, `wdata`, formatted load data and the misaligned flag.

## Test plan
- LW at 0x100, `dmem_ready` high on the 2nd BUSY cycle with rdata 0xDEADBEEF:
  - `stall` is high for 3 cycles.
  - In DONE: `out_valid=1`, `read_data_out=0xDEADBEEF`, `rd_out` and controls match the inputs.
- LB and LBU at 0x103 with rdata 0x80FF1234:
  - LB gives `read_data_out=0xFFFFFF80`.
  - LBU gives `read_data_out=0x00000080`.
  - `dmem_addr=0x100` in both cases.
- SH at 0x102 with data 0x0000ABCD:
  - `dmem_we=1`, `dmem_be=4'b1100`, `dmem_wdata=0xABCDABCD`, `dmem_addr=0x100`.
  - `reg_write_out=0`.
- LW at 0x101:
  - Same cycle: `misaligned_out=1`, `out_valid=1`, `reg_write_out=0`.
  - `dmem_req` and `stall` never rise.
- Non-memory instruction, rd=5, ALU result 0x2A:
  - Same cycle: `out_valid=1`, `alu_result_out=0x2A`, `stall=0`.
- Timeout and reset, with TIMEOUT_CYCLES=4:
  - `dmem_ready` held low gives DONE with `bus_err_out=1` and `reg_write_out=0` after 4 BUSY cycles.
  - `reset` asserted mid-BUSY gives `dmem_req=0` and `stall=0` on the next cycle.
